// File: rtl/mac_div_block.sv
// mac_div_block -- iterative unsigned restoring divider for the MAC datapath.
//
// Divides a chained dividend of 1, 2 or 4 MIN_WIDTH lanes (selected by cfg)
// by a single MIN_WIDTH divisor. One quotient bit is produced per enabled
// clock in RUN. Results are registered and presented with a one-cycle done.
//
// Ports:
//   clk   : clock
//   rst   : asynchronous active-low reset
//   en    : clock enable; low freezes all state and masks start
//   start : division request, sampled in IDLE with en high
//   cfg   : lane configuration, only cfg[1:0] decoded
//   A     : dividend, low k*MIN_WIDTH bits used
//   B     : divisor
//   busy  : high while a division is in RUN or DONE
//   done  : one-cycle pulse; Q, R, dz valid from this cycle
//   Q     : quotient, bits at/above k*MIN_WIDTH are zero
//   R     : remainder
//   dz    : divide-by-zero flag

`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 2
`endif
`ifndef MAC_SINGLE
`define MAC_SINGLE 2'b00
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'b01
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'b10
`endif

module mac_div_block #(
  parameter int MIN_WIDTH = 8,
  parameter int LANES     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          start,
  input  logic [`MAC_CONF_WIDTH-1:0]    cfg,
  input  logic [LANES*MIN_WIDTH-1:0]    A,
  input  logic [MIN_WIDTH-1:0]          B,
  output logic                          busy,
  output logic                          done,
  output logic [LANES*MIN_WIDTH-1:0]    Q,
  output logic [MIN_WIDTH-1:0]          R,
  output logic                          dz
);

  localparam int DW = LANES * MIN_WIDTH;
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] DW_C = CW'(DW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]        dvd;     // dividend, left-aligned so the next bit is always the MSB
  logic [DW-1:0]        quo;
  logic [MIN_WIDTH-1:0] prem;
  logic [MIN_WIDTH-1:0] dsr;
  logic                 dz_r;
  logic [CW-1:0]        cnt;

  logic                 cfg_ok;
  logic [CW-1:0]        act_bits;
  logic [DW-1:0]        act_mask;
  logic [DW-1:0]        a_align;

  logic [MIN_WIDTH:0]   sh;
  logic [MIN_WIDTH-1:0] diff;
  logic                 fits;
  logic [MIN_WIDTH-1:0] prem_nx;

  // Lane decode and dividend alignment
  always_comb begin
    cfg_ok   = 1'b0;
    act_bits = '0;
    case (cfg[1:0])
      `MAC_SINGLE: begin cfg_ok = 1'b1;          act_bits = CW'(MIN_WIDTH);     end
      `MAC_DUAL:   begin cfg_ok = (LANES >= 2);  act_bits = CW'(2 * MIN_WIDTH); end
      `MAC_QUAD:   begin cfg_ok = (LANES >= 4);  act_bits = CW'(4 * MIN_WIDTH); end
      default:     ;
    endcase
    if (!cfg_ok) act_bits = '0;
    act_mask = (act_bits >= DW_C) ? '1 : ~({DW{1'b1}} << act_bits);
    a_align  = (A & act_mask) << (DW_C - act_bits);
  end

  // Restoring step. The partial remainder is conceptually MIN_WIDTH+1 bits
  // after the shift; the stored value is always < divisor, so only MIN_WIDTH
  // bits are kept, and the subtraction can be done modulo 2^MIN_WIDTH because
  // it is only used when the true difference fits.
  always_comb begin
    sh      = {prem, dvd[DW-1]};
    fits    = (sh >= {1'b0, dsr});
    diff    = sh[MIN_WIDTH-1:0] - dsr;
    prem_nx = fits ? diff : sh[MIN_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (en && start) begin
          if (!cfg_ok || B == '0) state_nx = DONE;
          else                    state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (en && cnt == CW'(1)) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd  <= '0;
      quo  <= '0;
      prem <= '0;
      dsr  <= '0;
      dz_r <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
      Q    <= '0;
      R    <= '0;
      dz   <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (en && start) begin
            dvd  <= a_align;
            dsr  <= B;
            prem <= '0;
            quo  <= '0;
            dz_r <= 1'b0;
            cnt  <= act_bits;
            if (cfg_ok && B == '0) begin
              quo  <= act_mask;
              dz_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (en) begin
            dvd  <= dvd << 1;
            prem <= prem_nx;
            quo  <= {quo[DW-2:0], fits};
            cnt  <= cnt - CW'(1);
          end
        end
        DONE: begin
          Q  <= quo;
          R  <= prem;
          dz <= dz_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mac_div_block.md
Name: mac_div_block

Overview:
- Iterative unsigned divider, the inverse of the MAC multiply path.
- Divides a chained dividend (1, 2 or 4 MIN_WIDTH lanes, selected by cfg using the mac_const.vh encodings `MAC_SINGLE/`MAC_DUAL/`MAC_QUAD) by a single MIN_WIDTH divisor.
- Restoring algorithm, one quotient bit per enabled cycle, start/done handshake.
- Sits beside the multiply block in the MAC datapath for normalisation/scaling operations.

Parameters:
- MIN_WIDTH, 8, lane width; divisor and remainder width.
- LANES, 4, maximum chained lanes; dividend/quotient width = LANES*MIN_WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  clock enable; when low, all state holds and start is ignored
- start  input  1  request a division; sampled only in IDLE with en high
- cfg  input  `MAC_CONF_WIDTH  lane configuration; only cfg[1:0] is decoded
- A  input  LANES*MIN_WIDTH  dividend; only the low k*MIN_WIDTH bits are used (k=1/2/4)
- B  input  MIN_WIDTH  divisor
- busy  output  1  high in RUN and DONE states
- done  output  1  one-cycle pulse; Q, R and dz are valid from this cycle
- Q  output  LANES*MIN_WIDTH  quotient; bits at and above k*MIN_WIDTH are 0
- R  output  MIN_WIDTH  remainder
- dz  output  1  divide-by-zero flag, valid with done

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE
  - busy=0, done=0, Q=0, R=0, dz=0
  - iteration counter=0
- IDLE, start=1 and en=1:
  - Latch A masked to the active width, B, and k decoded from cfg[1:0].
  - If cfg[1:0] is not a valid encoding: go to DONE with Q=0, R=0, dz=0.
  - Else if B==0: go to DONE with Q = all-ones over the active width (upper bits 0), R=0, dz=1.
  - Else: clear the partial remainder, counter = k*MIN_WIDTH, go to RUN.
- RUN, each cycle with en=1:
  - Shift the partial remainder (MIN_WIDTH+1 bits) left, bringing in the dividend MSB.
  - Subtract B. If the result is non-negative, keep it and shift in a quotient bit of 1; otherwise restore and shift in 0.
  - Decrement the counter. After the last iteration (counter 1 to 0), go to DONE.
- DONE:
  - done=1 for exactly one cycle, regardless of en.
  - Q/R/dz are updated in that cycle, then state returns to IDLE.
- Latency:
  - Valid division: done is high N+1 clock edges after the start-sampling edge, where N=k*MIN_WIDTH (9 single, 17 dual, 33 quad), with no en stalls.
  - Zero divisor or invalid cfg: done on the edge after start.
- Outputs hold:
  - Q, R and dz hold their values after done until the next division reaches DONE.
  - They do not change during RUN.
- Stalls and ignored inputs:
  - start while busy=1 is ignored; no queueing.
  - A, B and cfg changes during RUN have no effect.
  - en low in RUN freezes the counter and datapath; latency extends by exactly the number of stalled cycles.
- Reset mid-operation: abandons the division immediately, no done pulse, outputs return to 0.
- Arithmetic:
  - Unsigned throughout.
  - The invariant A = Q*B + R with R < B holds for every non-zero B over the active width.

Test Plan:
- Single: cfg=`MAC_SINGLE, A=200, B=7, start one cycle -> done at edge 9, Q=28, R=4, dz=0; busy high through edges 1..9.
- Dual: cfg=`MAC_DUAL, A=50000, B=255 -> done at edge 17, Q=196, R=20. Repeat with A=0x00FF_C350 -> identical result, since upper bits are ignored.
- Quad: cfg=`MAC_QUAD, A=0xFFFF_FFFF, B=16 -> done at edge 33, Q=0x0FFF_FFFF, R=15. Then A=5, B=9 -> Q=0, R=5.
- Divide by zero: cfg=`MAC_DUAL, A=1234, B=0 -> done at edge 1, Q=0x0000_FFFF, R=0, dz=1.
- Stall/ignore: single 200/7 with en low for 3 cycles mid-RUN and start pulsed again at edge 4 -> done at edge 12, Q=28, R=4, exactly one done pulse.
- Reset mid-op: quad division, assert rst low at edge 10 -> outputs 0 immediately, no done. A new single 100/3 after release -> Q=33, R=1 at edge 9.
